// File: rtl/memory_block_swapper.sv
// Dual-ported word memory with a sequencer that swaps two equal-length blocks
// or copies block A onto block B, one word at a time, with modulo addressing.
module memory_block_swapper #(
  parameter int addr_w_N    = 7,
  parameter int data_w_Bits = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [addr_w_N-1:0]    address_w,
  input  logic [data_w_Bits-1:0] data_w,
  input  logic [addr_w_N-1:0]    address_r,
  output logic [data_w_Bits-1:0] data_r,
  input  logic                   start,
  input  logic                   mode,
  input  logic [addr_w_N-1:0]    address_A,
  input  logic [addr_w_N-1:0]    address_B,
  input  logic [addr_w_N-1:0]    len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [addr_w_N-1:0]    words_done
);
  localparam int DEPTH = 1 << addr_w_N;

  typedef enum logic [2:0] {IDLE, CHECK, READ, WR_A, WR_B, DONE, ERR} state_t;
  state_t state, state_nxt;

  logic [data_w_Bits-1:0] mem [DEPTH];
  logic [addr_w_N-1:0]    a_q, b_q, len_q, wd_q;
  logic                   mode_q;
  logic [data_w_Bits-1:0] ta_q, tb_q;
  logic [addr_w_N-1:0]    addr_a, addr_b, diff_ab, diff_ba, wd_inc;
  logic                   mem_we;
  logic [addr_w_N-1:0]    mem_addr;
  logic [data_w_Bits-1:0] mem_din;

  // All address arithmetic deliberately wraps at 2**addr_w_N.
  assign addr_a  = a_q + wd_q;
  assign addr_b  = b_q + wd_q;
  assign diff_ab = b_q - a_q;
  assign diff_ba = a_q - b_q;
  assign wd_inc  = wd_q + addr_w_N'(1);

  assign data_r = mem[address_r];

  // Single write port: the external port owns it only while idle.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = address_w;
    mem_din  = data_w;
    case (state)
      IDLE: mem_we = we;
      WR_A: begin mem_we = 1'b1; mem_addr = addr_a; mem_din = tb_q; end
      WR_B: begin mem_we = 1'b1; mem_addr = addr_b; mem_din = ta_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      // Blocks that overlap in either direction would corrupt themselves.
      CHECK: if (diff_ab < len_q || diff_ba < len_q) state_nxt = ERR;
             else if (len_q == '0)                   state_nxt = DONE;
             else                                    state_nxt = READ;
      READ:  state_nxt = mode_q ? WR_B : WR_A;
      WR_A:  state_nxt = WR_B;
      WR_B:  state_nxt = (wd_inc == len_q) ? DONE : READ;
      DONE:  state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      wd_q   <= '0;
      ta_q   <= '0;
      tb_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a_q    <= address_A;
        b_q    <= address_B;
        len_q  <= len;
        mode_q <= mode;
        wd_q   <= '0;
      end
      if (state == READ) begin
        ta_q <= mem[addr_a];
        tb_q <= mem[addr_b];
      end
      if (state == WR_B) wd_q <= wd_inc;
    end
  end

  assign busy       = (state == CHECK) || (state == READ) || (state == WR_A) || (state == WR_B);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign words_done = wd_q;

endmodule

// File: tb/tb_memory_block_swapper.sv
// Randomized bench for memory_block_swapper: a cycle-schedule model of each
// block operation is compared against the DUT on every falling clock edge.
module tb_memory_block_swapper;
  localparam int N = 7;
  localparam int W = 8;
  localparam int DEPTH = 1 << N;

  logic         clk, reset_n, we, start, mode, busy, done, err;
  logic [N-1:0] address_w, address_r, address_A, address_B, len, words_done;
  logic [W-1:0] data_w, data_r;

  int errors = 0;
  int checks = 0;

  memory_block_swapper #(.addr_w_N(N), .data_w_Bits(W)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .address_w(address_w), .data_w(data_w),
    .address_r(address_r), .data_r(data_r), .start(start), .mode(mode),
    .address_A(address_A), .address_B(address_B), .len(len),
    .busy(busy), .done(done), .err(err), .words_done(words_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: memory image plus an operation described by its start
  // snapshot and the cycle count t since the start was accepted.
  logic [W-1:0] mm     [DEPTH];
  bit           mv     [DEPTH];
  logic [W-1:0] snap_a [DEPTH];
  logic [W-1:0] snap_b [DEPTH];
  bit           act, bad, mmode;
  int           t, tend, sw;
  logic [N-1:0] ma, mb, ml, mwd;

  task automatic put(input logic [N-1:0] base, input int i, input logic [W-1:0] v);
    logic [N-1:0] ia;
    ia = base + N'(i);
    mm[ia] = v;
    mv[ia] = 1'b1;
  endtask

  task automatic model_step();
    logic [N-1:0] d1, d2, ia;
    if (!act) begin
      if (we) begin mm[address_w] = data_w; mv[address_w] = 1'b1; end
      if (start) begin
        ma = address_A; mb = address_B; ml = len; mmode = mode;
        mwd = '0; act = 1'b1; t = 1;
        d1 = mb - ma; d2 = ma - mb;
        bad  = (d1 < ml) || (d2 < ml);
        sw   = mmode ? 2 : 3;
        tend = (bad || ml == '0) ? 2 : 2 + sw * int'(ml);
        for (int i = 0; i < int'(ml); i++) begin
          ia = ma + N'(i); snap_a[i] = mm[ia];
          ia = mb + N'(i); snap_b[i] = mm[ia];
        end
      end
    end else begin
      t++;
      if (t > tend) act = 1'b0;
      else if (!bad && ml != '0) begin
        if (!mmode) begin
          if (t >= 4 && (t - 4) % 3 == 0) put(ma, (t - 4) / 3, snap_b[(t - 4) / 3]);
          if (t >= 5 && (t - 5) % 3 == 0) put(mb, (t - 5) / 3, snap_a[(t - 5) / 3]);
        end else if (t >= 4 && (t - 4) % 2 == 0) put(mb, (t - 4) / 2, snap_a[(t - 4) / 2]);
        mwd = (t >= tend) ? ml : N'((t - 2) / sw);
      end
    end
  endtask

  initial begin
    act = 1'b0; mwd = '0; t = 0; tend = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin act = 1'b0; mwd = '0; end
      else model_step();
    end
  end

  always @(negedge clk) begin
    check("busy", busy, act && t < tend);
    check("done", done, act && !bad && t == tend);
    check("err", err, act && bad && t == tend);
    check("words_done", words_done, mwd);
    if (mv[address_r]) check("data_r", data_r, mm[address_r]);
  end

  function automatic int exp_lat(input logic [N-1:0] a, b, l, input logic m);
    logic [N-1:0] d1, d2;
    d1 = b - a; d2 = a - b;
    if (d1 < l || d2 < l || l == '0) return 2;
    return (m ? 2 : 3) * int'(l) + 2;
  endfunction

  function automatic int exp_kind(input logic [N-1:0] a, b, l);
    logic [N-1:0] d1, d2;
    d1 = b - a; d2 = a - b;
    return (d1 < l || d2 < l) ? 2 : 1;
  endfunction

  task automatic wr(input logic [N-1:0] a, input logic [W-1:0] d);
    we = 1'b1; address_w = a; data_w = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [N-1:0] a, input logic [W-1:0] exp);
    @(posedge clk); #1;
    address_r = a;
    #1 check(name, data_r, exp);
  endtask

  // noise: 0 quiet, 1 keep writing 0xFF to address 0, 2 random input churn
  task automatic run_op(input logic [N-1:0] a, b, l, input logic m, input bit sw_we,
                        input logic [W-1:0] sw_d, input int noise, output int lat, output int kind);
    address_A = a; address_B = b; len = l; mode = m; start = 1'b1;
    if (sw_we) begin we = 1'b1; address_w = a; data_w = sw_d; end
    @(posedge clk); #1;
    start = 1'b0; we = 1'b0;
    lat = 0; kind = 0;
    while (lat < 500 && kind == 0) begin
      @(negedge clk); lat++;
      if (done) kind = 1;
      else if (err) kind = 2;
      else begin
        @(posedge clk); #1;
        address_r = N'($urandom);
        if (noise == 1) begin we = 1'b1; address_w = '0; data_w = 8'hFF; end
        else if (noise == 2) begin
          we = 1'($urandom); start = 1'($urandom); mode = 1'($urandom);
          address_w = N'($urandom); data_w = W'($urandom);
          address_A = N'($urandom); address_B = N'($urandom); len = N'($urandom);
        end
      end
    end
    check("op_completes", kind != 0, 1);
    @(posedge clk); #1;
    we = 1'b0; start = 1'b0;
  endtask

  initial begin
    int lat, kind;
    logic [N-1:0] ra, rb, rl;
    logic rm;
    reset_n = 1'b0; we = 1'b0; start = 1'b0; mode = 1'b0;
    address_w = '0; data_w = '0; address_r = '0;
    address_A = '0; address_B = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0); check("rst_done", done, 0);
    check("rst_err", err, 0);   check("rst_wd", words_done, 0);
    reset_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) wr(N'(a), W'($urandom));
    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
    wr(10, 8'hAA); wr(11, 8'hBB); wr(12, 8'hCC); wr(13, 8'hDD);

    run_op(0, 10, 4, 1'b0, 0, 0, 0, lat, kind);
    check("swap_kind", kind, 1); check("swap_lat", lat, 14);
    check("swap_wd", words_done, 4);
    read_chk("swap_m0", 0, 8'hAA);  read_chk("swap_m3", 3, 8'hDD);
    read_chk("swap_m10", 10, 8'h11); read_chk("swap_m13", 13, 8'h44);

    run_op(0, 10, 4, 1'b1, 0, 0, 0, lat, kind);
    check("copy_kind", kind, 1); check("copy_lat", lat, 10);
    read_chk("copy_m11", 11, 8'hBB); read_chk("copy_m13", 13, 8'hDD);
    read_chk("copy_m1", 1, 8'hBB);

    wr(126, 8'h5A); wr(127, 8'h6B); wr(0, 8'h7C);
    wr(2, 8'h91); wr(3, 8'h92); wr(4, 8'h93);
    run_op(126, 2, 3, 1'b0, 0, 0, 0, lat, kind);
    check("wrap_lat", lat, 11);
    read_chk("wrap_m126", 126, 8'h91); read_chk("wrap_m0", 0, 8'h93);
    read_chk("wrap_m2", 2, 8'h5A);     read_chk("wrap_m4", 4, 8'h7C);

    wr(5, 8'h55);
    run_op(5, 7, 4, 1'b0, 0, 0, 0, lat, kind);
    check("ovl_kind", kind, 2); check("ovl_lat", lat, 2);
    read_chk("ovl_m5", 5, 8'h55);
    run_op(0, 10, 0, 1'b0, 0, 0, 0, lat, kind);
    check("len0_kind", kind, 1); check("len0_lat", lat, 2);
    check("len0_wd", words_done, 0);

    run_op(0, 10, 2, 1'b0, 1, 8'hE1, 1, lat, kind);
    check("we_lat", lat, 8);
    read_chk("we_m0", 0, 8'hAA); read_chk("we_m10", 10, 8'hE1);

    wr(20, 8'h01); wr(21, 8'h02); wr(22, 8'h03);
    wr(30, 8'h04); wr(31, 8'h05); wr(32, 8'h06);
    address_A = 20; address_B = 30; len = 3; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("mid_busy", busy, 1); check("mid_wd", words_done, 1);
    start = 1'b1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0); check("arst_wd", words_done, 0);
    check("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0; reset_n = 1'b1;
    read_chk("arst_m20", 20, 8'h04); read_chk("arst_m30", 30, 8'h01);
    read_chk("arst_m21", 21, 8'h02); read_chk("arst_m31", 31, 8'h05);
    run_op(20, 30, 3, 1'b0, 0, 0, 0, lat, kind);
    check("post_lat", lat, 11);
    read_chk("post_m20", 20, 8'h01); read_chk("post_m21", 21, 8'h05);
    read_chk("post_m31", 31, 8'h02); read_chk("post_m32", 32, 8'h03);

    for (int k = 0; k < 40; k++) begin
      ra = N'($urandom);
      rb = ($urandom % 3 == 0) ? ra + N'($urandom_range(0, 6)) : N'($urandom);
      rl = N'($urandom_range(0, 8));
      rm = 1'($urandom);
      if ($urandom % 2 == 0) wr(N'($urandom), W'($urandom));
      run_op(ra, rb, rl, rm, 1'($urandom), W'($urandom), ($urandom % 2 == 0) ? 2 : 0, lat, kind);
      check("rnd_kind", kind, exp_kind(ra, rb, rl));
      check("rnd_lat", lat, exp_lat(ra, rb, rl, rm));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/memory_block_swapper.md
MEMORY_BLOCK_SWAPPER -- requirements
Module: memory_block_swapper

Interface
REQ-001 SHALL have parameter addr_w_N, default 7, meaning address width; memory depth is 2**addr_w_N words.
REQ-002 SHALL have parameter data_w_Bits, default 8, meaning word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port we, input, 1 bit: external write enable.
REQ-006 SHALL have port address_w, input, addr_w_N bits: external write address.
REQ-007 SHALL have port data_w, input, data_w_Bits bits: external write data.
REQ-008 SHALL have port address_r, input, addr_w_N bits: external read address.
REQ-009 SHALL have port data_r, output, data_w_Bits bits: read data, combinational mem[address_r] at all times.
REQ-010 SHALL have port start, input, 1 bit: block-operation request, sampled only in IDLE.
REQ-011 SHALL have port mode, input, 1 bit: 0 = swap blocks A and B, 1 = copy A to B.
REQ-012 SHALL have port address_A, input, addr_w_N bits: block A base address, sampled with start.
REQ-013 SHALL have port address_B, input, addr_w_N bits: block B base address, sampled with start.
REQ-014 SHALL have port len, input, addr_w_N bits: block length in words, sampled with start.
REQ-015 SHALL have port busy, output, 1 bit: high while a block operation is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port err, output, 1 bit: one-cycle rejection pulse.
REQ-018 SHALL have port words_done, output, addr_w_N bits: count of words completed in the current or last operation.

Function
REQ-019 SHALL implement FSM states IDLE, CHECK, READ, WR_A, WR_B, DONE, ERR.
REQ-020 SHALL, in IDLE with start=1, latch A, B, len and mode, clear words_done, and enter CHECK.
REQ-021 SHALL, in CHECK, enter ERR if (B-A) mod 2**addr_w_N < len or (A-B) mod 2**addr_w_N < len; else enter DONE if len=0; else enter READ.
REQ-022 SHALL, in READ, latch tA=mem[A+i] and tB=mem[B+i], where i = words_done and all addition is modulo 2**addr_w_N (wrap-around).
REQ-023 SHALL, in swap mode, go READ -> WR_A (mem[A+i]<=tB) -> WR_B (mem[B+i]<=tA).
REQ-024 SHALL, in copy mode, go READ -> WR_B (mem[B+i]<=tA), skipping WR_A.
REQ-025 SHALL, in WR_B, increment words_done, then go to DONE if words_done+1 = len, else back to READ.
REQ-026 SHALL assert busy=1 exactly in CHECK, READ, WR_A and WR_B.
REQ-027 SHALL pulse done=1 for one cycle in DONE, then return to IDLE.
REQ-028 SHALL pulse err=1 for one cycle in ERR, then return to IDLE with memory unchanged.
REQ-029 SHALL give a latency from the start-sampling edge to done high of 3*len+2 cycles in swap mode, 2*len+2 in copy mode, and 2 cycles when len=0.
REQ-030 SHALL perform external writes (we=1) only in IDLE; we while busy, DONE or ERR SHALL be ignored.
REQ-031 SHALL, when we=1 and start=1 in the same IDLE cycle, commit the external write, and the block operation SHALL see the written value.
REQ-032 SHALL ignore start outside IDLE, with no queuing.
REQ-033 SHALL let data_r reflect internal writes on the cycle after they occur.

Reset
REQ-034 SHALL, on reset_n low, immediately force the FSM to IDLE and set busy=0, done=0, err=0, words_done=0.
REQ-035 SHALL NOT clear memory contents on reset; a reset mid-operation leaves the memory partially swapped, and no done is issued.
REQ-036 SHALL ignore start until the first rising clk edge after reset_n deasserts.

Verification
REQ-037 SHALL cover: write mem[0..3]=11,22,33,44 and mem[10..13]=AA,BB,CC,DD; swap A=0, B=10, len=4 -> done 14 cycles after start; mem[0..3]=AA..DD and mem[10..13]=11..44; words_done=4.
REQ-038 SHALL cover: copy A=0, B=10, len=4 -> done after 10 cycles; mem[10..13]=mem[0..3]; block A unchanged.
REQ-039 SHALL cover: swap A=126, B=2, len=3 (wrap: words 126, 127, 0) -> contents exchanged across the address wrap.
REQ-040 SHALL cover: overlapping request A=5, B=7, len=4 -> err pulse at start+2, done=0, memory unchanged; len=0 -> done at start+2 with no writes.
REQ-041 SHALL cover: we=1 to address 0 while busy -> write dropped; we=1 plus start in IDLE -> new value swapped.
REQ-042 SHALL cover: reset_n low during WR_A -> busy=0 and words_done=0 asynchronously; words already swapped stay swapped; the next start runs normally.
